// File: rtl/adc_packetizer_if.sv
// adc_packetizer_if: byte-wide valid/ready/last stream from the packetizer to the Ethernet TX MAC.
// The master drives data/valid/last; the slave drives ready.

interface adc_packetizer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_last,
    output tx_ready
  );
endinterface

// File: rtl/adc_packetizer.sv
// adc_packetizer: buffers the no-backpressure ADC byte stream and cuts it into header+payload frames.
// Define ADC_PKT_CSUM_EN to append a big-endian 16-bit modular sum of the payload to every frame.

module adc_packetizer #(
  parameter int unsigned PAYLOAD_LEN = 1024,
  parameter int unsigned FIFO_DEPTH  = 4096,
  parameter logic [7:0]  MAGIC       = 8'hAD
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [7:0]              din,
  input  logic                    din_valid,
  adc_packetizer_if.master        tx,
  output logic                    overflow,
  output logic [15:0]             seq_num
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] DepthCnt  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PayLenCnt = CW'(PAYLOAD_LEN);
  localparam logic [15:0]   PayLen16  = 16'(PAYLOAD_LEN);

`ifdef ADC_PKT_CSUM_EN
  localparam bit CsumEn = 1'b1;
  typedef enum logic [1:0] {StIdle, StHdr, StPay, StCsum} state_e;
`else
  localparam bit CsumEn = 1'b0;
  typedef enum logic [1:0] {StIdle, StHdr, StPay} state_e;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          fifo_full;
  logic          wr_en;
  logic          rd_en;
  logic [7:0]    rd_data;

  // Frame state and registered outputs
  state_e        state_q, state_d;
  logic [1:0]    hdr_idx_q, hdr_idx_d;
  logic [15:0]   pay_cnt_q, pay_cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          tx_last_q, tx_last_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   seq_q, seq_d;
  logic          accept;
`ifdef ADC_PKT_CSUM_EN
  logic [15:0]   csum_q, csum_d;
`endif

  // The full test uses the registered count, so a same-cycle read never frees a slot.
  assign fifo_full = (count_q == DepthCnt);
  assign wr_en     = din_valid && !fifo_full;
  assign rd_data   = mem[rd_ptr_q];
  assign ovf_d     = ovf_q | (din_valid & fifo_full);
  assign count_d   = count_q + CW'(wr_en) - CW'(rd_en);
  assign accept    = tx_valid_q & tx.tx_ready;

  always_ff @(posedge clk) begin
    if (rstn && wr_en) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_comb begin
    state_d    = state_q;
    hdr_idx_d  = hdr_idx_q;
    pay_cnt_d  = pay_cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    seq_d      = seq_q;
    rd_en      = 1'b0;
`ifdef ADC_PKT_CSUM_EN
    csum_d     = csum_q;
`endif

    unique case (state_q)
      StIdle: begin
        // The whole payload is already buffered, so PAY can never underrun.
        if (count_q >= PayLenCnt) begin
          state_d    = StHdr;
          hdr_idx_d  = 2'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = MAGIC;
          tx_last_d  = 1'b0;
`ifdef ADC_PKT_CSUM_EN
          csum_d     = 16'h0000;
`endif
        end
      end

      StHdr: begin
        if (accept) begin
          hdr_idx_d = hdr_idx_q + 2'd1;
          unique case (hdr_idx_q)
            2'd0:    tx_data_d = {7'b0, ovf_q};
            2'd1:    tx_data_d = seq_q[15:8];
            2'd2:    tx_data_d = seq_q[7:0];
            default: begin
              state_d   = StPay;
              rd_en     = 1'b1;
              tx_data_d = rd_data;
              pay_cnt_d = 16'd1;
              tx_last_d = !CsumEn && (pay_cnt_d == PayLen16);
`ifdef ADC_PKT_CSUM_EN
              csum_d    = csum_q + {8'h00, rd_data};
`endif
            end
          endcase
        end
      end

      StPay: begin
        if (accept) begin
          if (pay_cnt_q == PayLen16) begin
`ifdef ADC_PKT_CSUM_EN
            state_d   = StCsum;
            tx_data_d = csum_q[15:8];
            tx_last_d = 1'b0;
`else
            state_d    = StIdle;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            seq_d      = seq_q + 16'd1;
`endif
          end else begin
            rd_en     = 1'b1;
            tx_data_d = rd_data;
            pay_cnt_d = pay_cnt_q + 16'd1;
            tx_last_d = !CsumEn && (pay_cnt_d == PayLen16);
`ifdef ADC_PKT_CSUM_EN
            csum_d    = csum_q + {8'h00, rd_data};
`endif
          end
        end
      end

`ifdef ADC_PKT_CSUM_EN
      StCsum: begin
        if (accept) begin
          if (!tx_last_q) begin
            tx_data_d = csum_q[7:0];
            tx_last_d = 1'b1;
          end else begin
            state_d    = StIdle;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            seq_d      = seq_q + 16'd1;
          end
        end
      end
`endif

      default: begin
        state_d    = StIdle;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      hdr_idx_q  <= 2'd0;
      pay_cnt_q  <= 16'd0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      ovf_q      <= 1'b0;
      seq_q      <= 16'h0000;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
`ifdef ADC_PKT_CSUM_EN
      csum_q     <= 16'h0000;
`endif
    end else begin
      state_q    <= state_d;
      hdr_idx_q  <= hdr_idx_d;
      pay_cnt_q  <= pay_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
      ovf_q      <= ovf_d;
      seq_q      <= seq_d;
      count_q    <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
`ifdef ADC_PKT_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign tx.tx_last  = tx_last_q;
  assign overflow    = ovf_q;
  assign seq_num     = seq_q;

endmodule

// File: tb/tb_adc_packetizer.sv
// tb_adc_packetizer: directed stimulus against a queue-based frame model checked every cycle,
// plus literal per-frame expectations. Honours ADC_PKT_CSUM_EN like the design.

module tb_adc_packetizer;
  localparam int unsigned PL    = 8;
  localparam int unsigned DEPTH = 16;
`ifdef ADC_PKT_CSUM_EN
  localparam int unsigned FL = PL + 6;
`else
  localparam int unsigned FL = PL + 4;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        din_valid = 1'b0;
  logic        overflow;
  logic [15:0] seq_num;

  adc_packetizer_if txif ();

  adc_packetizer #(
    .PAYLOAD_LEN(PL),
    .FIFO_DEPTH (DEPTH),
    .MAGIC      (8'hAD)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .din      (din),
    .din_valid(din_valid),
    .tx       (txif),
    .overflow (overflow),
    .seq_num  (seq_num)
  );

  always #4 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: bytes buffered but not yet sent, and position within the current frame.
  logic [7:0]  mfifo[$];
  bit          mvalid = 1'b0;
  int unsigned midx = 0;
  bit          movf = 1'b0;
  bit          hovf = 1'b0;
  logic [15:0] mseq = 16'h0000;
  logic [15:0] msum = 16'h0000;
  int          frames_done = 0;
  bit          armed = 1'b0;
  logic [8:0]  log_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte();
    if (midx == 0) return 8'hAD;
    if (midx == 1) return {7'b0, hovf};
    if (midx == 2) return mseq[15:8];
    if (midx == 3) return mseq[7:0];
    if (midx < 4 + PL) return mfifo[0];
    if (midx == 4 + PL) return msum[15:8];
    return msum[7:0];
  endfunction

  // Outputs settled since the last rising edge; inputs are those the next edge will see.
  always @(negedge clk) begin : compare
    int size0;
    if (armed) begin
      check("tx_valid", 32'(txif.tx_valid), 32'(mvalid));
      if (mvalid) begin
        if (midx >= 4 && midx < 4 + PL && mfifo.size() == 0) begin
          check("payload_underrun", 32'd0, 32'd1);
        end else begin
          check("tx_data", 32'(txif.tx_data), 32'(exp_byte()));
          check("tx_last", 32'(txif.tx_last), 32'(midx == FL - 1));
        end
      end else begin
        check("tx_last_idle", 32'(txif.tx_last), 32'd0);
      end
      check("overflow", 32'(overflow), 32'(movf));
      check("seq_num", 32'(seq_num), 32'(mseq));
    end
    if (rstn && txif.tx_valid && txif.tx_ready) log_q.push_back({txif.tx_last, txif.tx_data});

    if (!rstn) begin
      mfifo.delete();
      mvalid = 1'b0;
      midx   = 0;
      movf   = 1'b0;
      hovf   = 1'b0;
      mseq   = 16'h0000;
      msum   = 16'h0000;
    end else begin
      size0 = mfifo.size();
      if (mvalid && txif.tx_ready) begin
        if (midx == 0) hovf = movf;
        if (midx >= 4 && midx < 4 + PL && mfifo.size() > 0) msum = msum + 16'(mfifo.pop_front());
        if (midx == FL - 1) begin
          mvalid = 1'b0;
          mseq   = mseq + 16'd1;
          frames_done++;
        end else begin
          midx++;
        end
      end else if (!mvalid && size0 >= int'(PL)) begin
        mvalid = 1'b1;
        midx   = 0;
        msum   = 16'h0000;
      end
      if (din_valid) begin
        if (size0 < int'(DEPTH)) mfifo.push_back(din);
        else movf = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      din       = base + 8'(i);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
  endtask

  task automatic wait_frames(input string name, input int target, input int budget);
    int c = 0;
    while (frames_done < target && c < budget) begin
      tick();
      c++;
    end
    check({name, "_frame_seen"}, 32'(frames_done >= target), 32'd1);
  endtask

  // Pops one frame from the beat log and compares it with literal header/payload/checksum values.
  task automatic check_frame(input string nm, input logic [7:0] h1, input logic [15:0] sq,
                             input logic [7:0] base, input logic [15:0] cs);
    logic [7:0] e;
    logic [8:0] got;
    check({nm, "_len"}, 32'(log_q.size() >= FL), 32'd1);
    if (log_q.size() >= FL) begin
      for (int unsigned i = 0; i < FL; i++) begin
        got = log_q.pop_front();
        if (i == 0) e = 8'hAD;
        else if (i == 1) e = h1;
        else if (i == 2) e = sq[15:8];
        else if (i == 3) e = sq[7:0];
        else if (i < 4 + PL) e = base + 8'(i - 4);
        else if (i == 4 + PL) e = cs[15:8];
        else e = cs[7:0];
        check({nm, "_beat"}, 32'(got), {23'b0, i == FL - 1, e});
      end
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c;
    txif.tx_ready = 1'b0;
    repeat (3) tick();
    armed = 1'b1;
    check("rst_tx_valid", 32'(txif.tx_valid), 32'd0);
    check("rst_tx_data", 32'(txif.tx_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_seq_num", 32'(seq_num), 32'd0);
    rstn = 1'b1;
    tick();

    // One frame with the sink always ready
    txif.tx_ready = 1'b1;
    log_q.delete();
    feed(8'h00, 8);
    wait_frames("t1", 1, 200);
    check_frame("t1", 8'h00, 16'h0000, 8'h00, 16'h001C);
    check("t1_seq", 32'(seq_num), 32'd1);

    // Sink stalls every other cycle
    txif.tx_ready = 1'b0;
    feed(8'h10, 8);
    c = 0;
    while (frames_done < 2 && c < 300) begin
      txif.tx_ready = ~txif.tx_ready;
      tick();
      c++;
    end
    txif.tx_ready = 1'b1;
    check("t3_frame_seen", 32'(frames_done >= 2), 32'd1);
    check_frame("t3", 8'h00, 16'h0001, 8'h10, 16'h009C);

    // Sequence number wrap
    repeat (3) tick();
    force dut.seq_q = 16'hFFFF;
    mseq = 16'hFFFF;
    tick();
    release dut.seq_q;
    feed(8'h20, 8);
    wait_frames("t5", 3, 200);
    check_frame("t5", 8'h00, 16'hFFFF, 8'h20, 16'h011C);
    check("t5_seq_wrap", 32'(seq_num), 32'd0);

    // FIFO overflow with the sink blocked: 16 kept, 4 dropped
    txif.tx_ready = 1'b0;
    feed(8'h30, 20);
    tick();
    check("t4_overflow", 32'(overflow), 32'd1);
    txif.tx_ready = 1'b1;
    wait_frames("t4", 5, 300);
    check_frame("t4a", 8'h01, 16'h0000, 8'h30, 16'h019C);
    check_frame("t4b", 8'h01, 16'h0001, 8'h38, 16'h01DC);

    // Reset in the middle of a payload
    log_q.delete();
    feed(8'h50, 8);
    c = 0;
    while (log_q.size() < 9 && c < 100) begin
      tick();
      c++;
    end
    check("t6_mid_payload", 32'(log_q.size() >= 9), 32'd1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("t6_rst_valid", 32'(txif.tx_valid), 32'd0);
    check("t6_rst_overflow", 32'(overflow), 32'd0);
    check("t6_rst_seq", 32'(seq_num), 32'd0);
    log_q.delete();
    feed(8'h60, 4);
    repeat (10) tick();
    check("t6_no_early_frame", 32'(txif.tx_valid), 32'd0);
    feed(8'h64, 4);
    wait_frames("t6", 6, 200);
    check_frame("t6", 8'h00, 16'h0000, 8'h60, 16'h031C);
    check("t6_seq", 32'(seq_num), 32'd1);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
